clock_phase_monitor: RTL and testbench

- Consumes the two-phase non-overlapping clock pair (CLK1/CLK2) that the chip's clock generator produces from CLK.
- Verifies the 4-slot sequence 10,00,01,00 (CLK1,CLK2), locks onto it, and reports lock and faults.
- Issues registered per-phase enable strobes for single-clock-domain logic that must track the two-phase timing.
- Sits beside the clock generator and feeds status to debug/IO.

---
 rtl/clock_phase_monitor.sv | 156 +++++++++++++++
 tb/tb_clock_phase_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clock_phase_monitor.sv
// rtl/clock_phase_monitor.sv - two-phase clock sequence monitor with lock, fault flags and phase strobes
// Tracks the 10,00,01,00 (CLK1,CLK2) slot sequence and reports lock, errors, overlap and stall.
module clock_phase_monitor #(
  parameter int LOCK_CYCLES = 4,
  parameter int TIMEOUT     = 8,
  parameter int ERRW        = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CLK1_IN,
  input  logic            CLK2_IN,
  output logic            PH1_EN,
  output logic            PH2_EN,
  output logic            LOCK,
  output logic            ERR,
  output logic            OVERLAP,
  output logic            STALL,
  output logic [ERRW-1:0] ERR_CNT,
  output logic [1:0]      SLOT
);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [3:0]      LOCK_MAX = 4'(LOCK_CYCLES);
  localparam logic [7:0]      TO_MAX   = 8'(TIMEOUT);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  state_t          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
  logic [7:0]      to_cnt_q, to_cnt_d;
  logic            ph1_q, ph1_d;
  logic            ph2_q, ph2_d;
  logic            err_q, err_d;
  logic            lock_q, lock_d;
  logic            overlap_q, overlap_d;
  logic            stall_q, stall_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;

  logic [1:0] pat;
  logic [1:0] exp_pat;

  assign pat = {CLK1_IN, CLK2_IN};

  always_comb begin
    exp_pat = 2'b00;
    case (slot_q)
      2'd1:    exp_pat = 2'b01;
      2'd3:    exp_pat = 2'b10;
      default: exp_pat = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= HUNT;
      slot_q     <= 2'd0;
      lock_cnt_q <= 4'd0;
      to_cnt_q   <= 8'd0;
      ph1_q      <= 1'b0;
      ph2_q      <= 1'b0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
      overlap_q  <= 1'b0;
      stall_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      lock_cnt_q <= lock_cnt_d;
      to_cnt_q   <= to_cnt_d;
      ph1_q      <= ph1_d;
      ph2_q      <= ph2_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
      overlap_q  <= overlap_d;
      stall_q    <= stall_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    lock_cnt_d = lock_cnt_q;
    ph1_d      = 1'b0;
    ph2_d      = 1'b0;
    err_d      = 1'b0;
    overlap_d  = overlap_q | (pat == 2'b11);

    // Idle-low detector runs regardless of the sequence FSM.
    if (pat != 2'b00) begin
      to_cnt_d = 8'd0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 8'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    case (state_q)
      HUNT: begin
        slot_d     = 2'd0;
        lock_cnt_d = 4'd0;
        if (pat == 2'b10) begin
          state_d = TRACK;
          ph1_d   = 1'b1;
        end else if (pat == 2'b11) begin
          err_d = 1'b1;
        end
      end
      default: begin
        if (pat == exp_pat) begin
          slot_d = slot_q + 2'(1);
          if (pat == 2'b10) begin
            ph1_d = 1'b1;
            if (lock_cnt_q != LOCK_MAX) begin
              lock_cnt_d = lock_cnt_q + 4'(1);
            end
          end else if (pat == 2'b01) begin
            ph2_d = 1'b1;
          end
        end else begin
          // Overlap can never match, so it lands here with a single ERR.
          err_d      = 1'b1;
          slot_d     = 2'd0;
          lock_cnt_d = 4'd0;
          if (pat == 2'b10) begin
            state_d = TRACK;
            ph1_d   = 1'b1;
          end else begin
            state_d = HUNT;
          end
        end
      end
    endcase

    if (err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERRW'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end

    lock_d  = (state_d == TRACK) && (lock_cnt_d == LOCK_MAX);
    stall_d = (to_cnt_d == TO_MAX);
  end

  assign PH1_EN  = ph1_q;
  assign PH2_EN  = ph2_q;
  assign LOCK    = lock_q;
  assign ERR     = err_q;
  assign OVERLAP = overlap_q;
  assign STALL   = stall_q;
  assign ERR_CNT = err_cnt_q;
  assign SLOT    = slot_q;

endmodule

// File: tb/tb_clock_phase_monitor.sv
// tb/tb_clock_phase_monitor.sv - directed self-checking bench for clock_phase_monitor
// Drives the CLK1/CLK2 pattern per cycle and checks the registered outputs one cycle later.
module tb_clock_phase_monitor;

  logic       clk;
  logic       rst;
  logic       c1, c2;
  logic       ph1, ph2, lock, err, overlap, stall;
  logic [7:0] err_cnt;
  logic [1:0] slot;
  logic       s_ph1, s_ph2, s_lock, s_err, s_overlap, s_stall;
  logic [1:0] s_err_cnt;
  logic [1:0] s_slot;

  int checks   = 0;
  int failures = 0;

  logic [1:0] pats [4] = '{2'b10, 2'b00, 2'b01, 2'b00};

  clock_phase_monitor u_dut (
    .CLK(clk), .RST(rst), .CLK1_IN(c1), .CLK2_IN(c2),
    .PH1_EN(ph1), .PH2_EN(ph2), .LOCK(lock), .ERR(err),
    .OVERLAP(overlap), .STALL(stall), .ERR_CNT(err_cnt), .SLOT(slot)
  );

  clock_phase_monitor #(.ERRW(2)) u_sat (
    .CLK(clk), .RST(rst), .CLK1_IN(c1), .CLK2_IN(c2),
    .PH1_EN(s_ph1), .PH2_EN(s_ph2), .LOCK(s_lock), .ERR(s_err),
    .OVERLAP(s_overlap), .STALL(s_stall), .ERR_CNT(s_err_cnt), .SLOT(s_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [1:0] p);
    {c1, c2} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {c1, c2} = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ph1 !== 1'b0) begin failures++; $display("FAIL reset_ph1 got=%b exp=0", ph1); end
    checks++; if (ph2 !== 1'b0) begin failures++; $display("FAIL reset_ph2 got=%b exp=0", ph2); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b exp=0", lock); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL reset_overlap got=%b exp=0", overlap); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (slot !== 2'd0) begin failures++; $display("FAIL reset_slot got=%0d exp=0", slot); end
  endtask

  task automatic test_clean();
    do_reset();
    for (int n = 0; n < 24; n++) begin
      step(pats[n % 4]);
      checks++; if (ph1 !== (n % 4 == 0)) begin failures++; $display("FAIL clean_ph1 n=%0d got=%b exp=%b", n, ph1, (n % 4 == 0)); end
      checks++; if (ph2 !== (n % 4 == 2)) begin failures++; $display("FAIL clean_ph2 n=%0d got=%b exp=%b", n, ph2, (n % 4 == 2)); end
      checks++; if (lock !== (n >= 16)) begin failures++; $display("FAIL clean_lock n=%0d got=%b exp=%b", n, lock, (n >= 16)); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL clean_err n=%0d got=%b exp=0", n, err); end
      checks++; if (slot !== 2'(n % 4)) begin failures++; $display("FAIL clean_slot n=%0d got=%0d exp=%0d", n, slot, n % 4); end
    end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_gap_error();
    step(2'b10);
    step(2'b00);
    step(2'b00);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL gap_err got=%b exp=1", err); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL gap_lock got=%b exp=0", lock); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL gap_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (slot !== 2'd0) begin failures++; $display("FAIL gap_slot got=%0d exp=0", slot); end
    checks++; if (ph2 !== 1'b0) begin failures++; $display("FAIL gap_ph2 got=%b exp=0", ph2); end
    step(2'b00);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gap_hunt_err got=%b exp=0", err); end
    step(2'b10);
    checks++; if (ph1 !== 1'b1) begin failures++; $display("FAIL gap_acq_ph1 got=%b exp=1", ph1); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL gap_acq_lock got=%b exp=0", lock); end
    for (int k = 0; k < 16; k++) begin
      step(pats[(k + 1) % 4]);
      checks++; if (lock !== (k == 15)) begin failures++; $display("FAIL relock k=%0d got=%b exp=%b", k, lock, (k == 15)); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL relock_err k=%0d got=%b exp=0", k, err); end
    end
  endtask

  task automatic test_overlap();
    step(2'b11);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovl_err got=%b exp=1", err); end
    checks++; if (overlap !== 1'b1) begin failures++; $display("FAIL ovl_flag got=%b exp=1", overlap); end
    checks++; if (err_cnt !== 8'd2) begin failures++; $display("FAIL ovl_err_cnt got=%0d exp=2", err_cnt); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL ovl_lock got=%b exp=0", lock); end
    checks++; if (ph1 !== 1'b0) begin failures++; $display("FAIL ovl_ph1 got=%b exp=0", ph1); end
    step(2'b00);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ovl_single_err got=%b exp=0", err); end
    checks++; if (err_cnt !== 8'd2) begin failures++; $display("FAIL ovl_cnt_hold got=%0d exp=2", err_cnt); end
    step(2'b10);
    checks++; if (overlap !== 1'b1) begin failures++; $display("FAIL ovl_sticky got=%b exp=1", overlap); end
    checks++; if (ph1 !== 1'b1) begin failures++; $display("FAIL ovl_reacq_ph1 got=%b exp=1", ph1); end
  endtask

  task automatic test_reacquire();
    step(2'b10);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL reacq_err got=%b exp=1", err); end
    checks++; if (ph1 !== 1'b1) begin failures++; $display("FAIL reacq_ph1 got=%b exp=1", ph1); end
    checks++; if (slot !== 2'd0) begin failures++; $display("FAIL reacq_slot got=%0d exp=0", slot); end
    checks++; if (err_cnt !== 8'd3) begin failures++; $display("FAIL reacq_err_cnt got=%0d exp=3", err_cnt); end
    step(2'b00);
    checks++; if (slot !== 2'd1) begin failures++; $display("FAIL reacq_track_slot got=%0d exp=1", slot); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reacq_track_err got=%b exp=0", err); end
  endtask

  task automatic test_stall();
    do_reset();
    checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL stall_ovl_cleared got=%b exp=0", overlap); end
    for (int i = 0; i < 10; i++) begin
      step(2'b00);
      checks++; if (stall !== (i >= 7)) begin failures++; $display("FAIL stall i=%0d got=%b exp=%b", i, stall, (i >= 7)); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL stall_err i=%0d got=%b exp=0", i, err); end
    end
    step(2'b10);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_clear got=%b exp=0", stall); end
    checks++; if (ph1 !== 1'b1) begin failures++; $display("FAIL stall_acq_ph1 got=%b exp=1", ph1); end
  endtask

  task automatic test_err_sat();
    logic [1:0] sat_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'b11);
      checks++; if (s_err_cnt !== sat_exp[i]) begin failures++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, s_err_cnt, sat_exp[i]); end
      checks++; if (err_cnt !== 8'(i + 1)) begin failures++; $display("FAIL wide_cnt i=%0d got=%0d exp=%0d", i, err_cnt, i + 1); end
      checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL sat_err i=%0d got=%b exp=1", i, s_err); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int n = 0; n < 17; n++) step(pats[n % 4]);
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL ar_prelock got=%b exp=1", lock); end
    checks++; if (ph1 !== 1'b1) begin failures++; $display("FAIL ar_pre_ph1 got=%b exp=1", ph1); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL ar_lock got=%b exp=0", lock); end
    checks++; if (ph1 !== 1'b0) begin failures++; $display("FAIL ar_ph1 got=%b exp=0", ph1); end
    checks++; if (ph2 !== 1'b0) begin failures++; $display("FAIL ar_ph2 got=%b exp=0", ph2); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ar_err got=%b exp=0", err); end
    checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL ar_overlap got=%b exp=0", overlap); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ar_stall got=%b exp=0", stall); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL ar_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (slot !== 2'd0) begin failures++; $display("FAIL ar_slot got=%0d exp=0", slot); end
    rst = 1'b0;
    step(2'b10);
    checks++; if (ph1 !== 1'b1) begin failures++; $display("FAIL ar_acq_ph1 got=%b exp=1", ph1); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL ar_acq_lock got=%b exp=0", lock); end
    for (int k = 0; k < 16; k++) begin
      step(pats[(k + 1) % 4]);
      checks++; if (lock !== (k == 15)) begin failures++; $display("FAIL ar_relock k=%0d got=%b exp=%b", k, lock, (k == 15)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    {c1, c2} = 2'b00;
    test_reset();
    test_clean();
    test_gap_error();
    test_overlap();
    test_reacquire();
    test_stall();
    test_err_sat();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
